ddr3_frame_writer: RTL and testbench

//  Write-DMA stage feeding the DDR3 memory interface. Packs the RGB565 camera

---
 rtl/ddr3_frame_writer_if.sv | 50 +++++
 rtl/ddr3_frame_writer.sv | 206 ++++++++++++++++++++
 tb/tb_ddr3_frame_writer.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ddr3_frame_writer_if.sv
// Pixel stream and DDR3 app-port bundle for the frame writer.
// master = DMA side, slave = camera/DDR3 side.
interface ddr3_frame_writer_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 128,
  parameter int PIX_WIDTH  = 16
);
  logic                    I_calib_done;
  logic                    I_frame_start;
  logic [PIX_WIDTH-1:0]    I_pix_data;
  logic                    I_pix_valid;
  logic                    O_pix_ready;
  logic                    I_cmd_ready;
  logic [2:0]              O_cmd;
  logic                    O_cmd_en;
  logic [ADDR_WIDTH-1:0]   O_addr;
  logic [5:0]              O_burst_number;
  logic                    I_wr_data_rdy;
  logic [DATA_WIDTH-1:0]   O_wr_data;
  logic                    O_wr_data_en;
  logic                    O_wr_data_end;
  logic [DATA_WIDTH/8-1:0] O_wr_data_mask;
  logic                    O_frame_done;
  logic [1:0]              O_frame_idx;
  logic                    O_frame_err;

  modport master (
    input  I_calib_done, I_frame_start,
    input  I_pix_data, I_pix_valid,
    input  I_cmd_ready, I_wr_data_rdy,
    output O_pix_ready, O_cmd, O_cmd_en,
    output O_addr, O_burst_number,
    output O_wr_data, O_wr_data_en,
    output O_wr_data_end, O_wr_data_mask,
    output O_frame_done, O_frame_idx,
    output O_frame_err
  );

  modport slave (
    output I_calib_done, I_frame_start,
    output I_pix_data, I_pix_valid,
    output I_cmd_ready, I_wr_data_rdy,
    input  O_pix_ready, O_cmd, O_cmd_en,
    input  O_addr, O_burst_number,
    input  O_wr_data, O_wr_data_en,
    input  O_wr_data_end, O_wr_data_mask,
    input  O_frame_done, O_frame_idx,
    input  O_frame_err
  );
endinterface

// File: rtl/ddr3_frame_writer.sv
// Packs RGB565 pixels into ping-pong burst banks and writes
// them as DDR3 bursts into rotating frame buffers.
module ddr3_frame_writer #(
  parameter int ADDR_WIDTH   = 28,
  parameter int DATA_WIDTH   = 128,
  parameter int PIX_WIDTH    = 16,
  parameter int BURST_BEATS  = 8,
  parameter int FRAME_PIXELS = 921600,
  parameter int BASE_ADDR    = 0,
  parameter int FRAME_STRIDE = 2**21,
  parameter int NUM_FRAMES   = 3
) (
  input logic I_clk,
  input logic I_rst,
  ddr3_frame_writer_if.master bus
);
  localparam int PPW = DATA_WIDTH / PIX_WIDTH;
  localparam int KW  = (PPW > 1) ? $clog2(PPW) : 1;
  localparam int BW  = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam int PCW = $clog2(FRAME_PIXELS + 1);
  localparam int WW  = DATA_WIDTH - PIX_WIDTH;

  typedef enum logic {F_IDLE, F_ACTIVE} f_state_t;
  typedef enum logic [1:0] {WIDLE, WCMD, WDATA} w_state_t;

  f_state_t f_state, f_next;
  w_state_t w_state, w_next;

  logic [DATA_WIDTH-1:0] bank_mem [2][BURST_BEATS];
  logic [WW-1:0]         word_q;
  logic [KW-1:0]         pix_k;
  logic [BW-1:0]         fill_beat, wr_beat;
  logic                  fill_bank, wr_bank;
  logic [1:0]            bank_full;
  logic [PCW-1:0]        pix_cnt;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [1:0]            frame_idx, idx_next;
  logic                  start_pend, done_q, err_q;

  logic all_acc, base_ready, last_acc, abort;
  logic pix_ready, acc, word_done, bank_done;
  logic beat_xfer, burst_end, frame_end;
  logic calib_lost, keep_burst, keep;

  function automatic logic [ADDR_WIDTH-1:0] frame_base(
    input logic [1:0] idx
  );
    longint a;
    a = longint'(BASE_ADDR)
      + longint'(idx) * longint'(FRAME_STRIDE);
    return a[ADDR_WIDTH-1:0];
  endfunction

  assign all_acc    = pix_cnt == PCW'(FRAME_PIXELS);
  assign base_ready = f_state == F_ACTIVE
                   && bus.I_calib_done
                   && !bank_full[fill_bank] && !all_acc;
  assign last_acc   = base_ready && bus.I_pix_valid
                   && pix_cnt == PCW'(FRAME_PIXELS - 1);
  assign abort      = f_state == F_ACTIVE && bus.I_frame_start
                   && !all_acc && !last_acc;
  assign pix_ready  = base_ready && !abort;
  assign acc        = bus.I_pix_valid && pix_ready;
  assign word_done  = acc && pix_k == KW'(PPW - 1);
  assign bank_done  = word_done
                   && fill_beat == BW'(BURST_BEATS - 1);
  assign beat_xfer  = w_state == WDATA && bus.I_wr_data_rdy;
  assign burst_end  = beat_xfer
                   && wr_beat == BW'(BURST_BEATS - 1);
  assign frame_end  = f_state == F_ACTIVE && all_acc
                   && bank_full == 2'b00 && w_state == WIDLE;
  assign calib_lost = f_state == F_ACTIVE
                   && !bus.I_calib_done && w_state == WIDLE;
  assign keep_burst = w_state == WDATA
                   || (w_state == WCMD && bus.I_cmd_ready);
  assign keep       = keep_burst && !burst_end;
  assign idx_next   = (frame_idx == 2'(NUM_FRAMES - 1))
                   ? 2'd0 : frame_idx + 2'd1;

  // Frame FSM next state
  always_comb begin
    f_next = f_state;
    unique case (f_state)
      F_IDLE:
        if (bus.I_frame_start && bus.I_calib_done)
          f_next = F_ACTIVE;
      F_ACTIVE:
        if (frame_end)
          f_next = ((start_pend || bus.I_frame_start)
                   && bus.I_calib_done) ? F_ACTIVE : F_IDLE;
        else if (calib_lost)
          f_next = F_IDLE;
      default: f_next = F_IDLE;
    endcase
  end

  // Write FSM next state; an accepted command always finishes
  always_comb begin
    w_next = w_state;
    unique case (w_state)
      WIDLE:
        if (f_state == F_ACTIVE && bus.I_calib_done
            && bank_full[wr_bank] && !abort)
          w_next = WCMD;
      WCMD:
        if (bus.I_cmd_ready) w_next = WDATA;
        else if (abort)      w_next = WIDLE;
      WDATA:
        if (burst_end) w_next = WIDLE;
      default: w_next = WIDLE;
    endcase
  end

  // Burst bank storage, written one full word at a time
  always_ff @(posedge I_clk) begin
    if (word_done)
      bank_mem[fill_bank][fill_beat] <= {bus.I_pix_data, word_q};
  end

  // State, packing, bank bookkeeping and address tracking
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      f_state    <= F_IDLE;
      w_state    <= WIDLE;
      word_q     <= '0;
      pix_k      <= '0;
      fill_beat  <= '0;
      wr_beat    <= '0;
      fill_bank  <= 1'b0;
      wr_bank    <= 1'b0;
      bank_full  <= 2'b00;
      pix_cnt    <= '0;
      wr_addr    <= frame_base(2'd0);
      frame_idx  <= 2'd0;
      start_pend <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      f_state <= f_next;
      w_state <= w_next;
      done_q  <= frame_end;
      err_q   <= abort;
      if (acc) begin
        for (int k = 0; k < PPW - 1; k++)
          if (pix_k == KW'(k))
            word_q[k*PIX_WIDTH +: PIX_WIDTH] <= bus.I_pix_data;
        pix_k   <= pix_k + KW'(1);
        pix_cnt <= pix_cnt + PCW'(1);
      end
      if (word_done) begin
        fill_beat <= bank_done ? '0 : fill_beat + BW'(1);
        if (bank_done) fill_bank <= ~fill_bank;
      end
      for (int b = 0; b < 2; b++) begin
        if (bank_done && fill_bank == 1'(b))
          bank_full[b] <= 1'b1;
        else if (burst_end && wr_bank == 1'(b))
          bank_full[b] <= 1'b0;
      end
      if (w_state == WCMD && bus.I_cmd_ready)
        wr_addr <= wr_addr + ADDR_WIDTH'(BURST_BEATS * PPW);
      if (beat_xfer)
        wr_beat <= burst_end ? '0 : wr_beat + BW'(1);
      if (burst_end) wr_bank <= ~wr_bank;
      if (f_state == F_ACTIVE && all_acc && bus.I_frame_start)
        start_pend <= 1'b1;
      if (abort) begin
        pix_k     <= '0;
        pix_cnt   <= '0;
        fill_beat <= '0;
        wr_addr   <= frame_base(frame_idx);
        fill_bank <= keep_burst ? ~wr_bank : wr_bank;
        bank_full <= keep ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
      end
      if (frame_end) begin
        frame_idx  <= idx_next;
        wr_addr    <= frame_base(idx_next);
        pix_cnt    <= '0;
        start_pend <= 1'b0;
      end
      if (calib_lost) begin
        pix_k      <= '0;
        pix_cnt    <= '0;
        fill_beat  <= '0;
        fill_bank  <= wr_bank;
        bank_full  <= 2'b00;
        wr_addr    <= frame_base(frame_idx);
        start_pend <= 1'b0;
      end
    end
  end

  assign bus.O_pix_ready    = pix_ready;
  assign bus.O_cmd          = 3'b000;
  assign bus.O_cmd_en       = w_state == WCMD;
  assign bus.O_addr         = (w_state == WCMD) ? wr_addr : '0;
  assign bus.O_burst_number = 6'(BURST_BEATS - 1);
  assign bus.O_wr_data      = (w_state == WDATA)
                            ? bank_mem[wr_bank][wr_beat] : '0;
  assign bus.O_wr_data_en   = w_state == WDATA;
  assign bus.O_wr_data_end  = w_state == WDATA;
  assign bus.O_wr_data_mask = '0;
  assign bus.O_frame_done   = done_q;
  assign bus.O_frame_idx    = frame_idx;
  assign bus.O_frame_err    = err_q;
endmodule

// File: tb/tb_ddr3_frame_writer.sv
// Scoreboard bench for ddr3_frame_writer.
// Small burst/frame sizes so every path runs quickly.
module tb_ddr3_frame_writer;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int PW = 16;
  localparam int BB = 2;
  localparam int FP = 128;
  localparam int FS = 4096;
  localparam int NF = 3;

  logic I_clk = 1'b0;
  logic I_rst = 1'b1;
  always #5 I_clk = ~I_clk;

  ddr3_frame_writer_if #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIX_WIDTH(PW)
  ) bus ();

  ddr3_frame_writer #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .PIX_WIDTH(PW),
    .BURST_BEATS(BB), .FRAME_PIXELS(FP), .BASE_ADDR(0),
    .FRAME_STRIDE(FS), .NUM_FRAMES(NF)
  ) dut (
    .I_clk(I_clk),
    .I_rst(I_rst),
    .bus(bus)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [AW-1:0] q_addr[$];
  logic [DW-1:0] q_beat[$];
  logic [DW-1:0] acc_word = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] first_beat = '0;
  logic [AW-1:0] prev_addr = '0;
  logic          prev_wait = 1'b0;
  logic          rnd_rdy = 1'b0;
  int acc_k = 0, acc_w = 0, m_cnt = 0, m_idx = 0;
  int exp_done = 0, n_done = 0, n_errp = 0;
  int n_cmd = 0, n_beats = 0;

  task automatic model_pix(input logic [PW-1:0] p);
    acc_word[acc_k*PW +: PW] = p;
    acc_k++;
    if (acc_k == DW / PW) begin
      q_beat.push_back(acc_word);
      acc_k = 0;
      acc_w++;
      if (acc_w == BB) begin
        q_addr.push_back(m_addr);
        m_addr = m_addr + AW'(BB * 8);
        acc_w = 0;
      end
    end
    m_cnt++;
    if (m_cnt == FP) begin
      m_cnt = 0;
      exp_done++;
      m_idx = (m_idx + 1) % NF;
      m_addr = AW'(m_idx * FS);
    end
  endtask

  task automatic model_abort();
    repeat (acc_w) void'(q_beat.pop_back());
    acc_k = 0;
    acc_w = 0;
    m_cnt = 0;
    m_addr = AW'(m_idx * FS);
  endtask

  task automatic model_reset();
    q_addr.delete();
    q_beat.delete();
    acc_k = 0;
    acc_w = 0;
    m_cnt = 0;
    m_idx = 0;
    m_addr = '0;
    prev_wait = 1'b0;
  endtask

  // Monitor: sample settled values mid low phase
  initial begin
    forever begin
      @(negedge I_clk);
      #2;
      if (I_rst) begin
        prev_wait = 1'b0;
      end else begin
        chk("wr_end", 128'(bus.O_wr_data_end),
            128'(bus.O_wr_data_en));
        if (bus.O_cmd_en) begin
          if (prev_wait)
            chk("addr_hold", 128'(bus.O_addr), 128'(prev_addr));
          if (bus.I_cmd_ready) begin
            n_cmd++;
            prev_wait = 1'b0;
            if (q_addr.size() == 0)
              chk("cmd_extra", 128'(q_addr.size()), 128'(1));
            else
              chk("cmd_addr", 128'(bus.O_addr),
                  128'(q_addr.pop_front()));
          end else begin
            prev_wait = 1'b1;
            prev_addr = bus.O_addr;
          end
        end else begin
          prev_wait = 1'b0;
        end
        if (bus.O_wr_data_en && bus.I_wr_data_rdy) begin
          n_beats++;
          if (n_beats == 1) first_beat = bus.O_wr_data;
          if (q_beat.size() == 0)
            chk("beat_extra", 128'(q_beat.size()), 128'(1));
          else
            chk("beat_data", bus.O_wr_data, q_beat.pop_front());
        end
        if (bus.I_pix_valid && bus.O_pix_ready)
          model_pix(bus.I_pix_data);
        if (bus.O_frame_done) n_done++;
        if (bus.O_frame_err) n_errp++;
      end
    end
  end

  // Random write-data backpressure when enabled
  initial begin
    forever begin
      @(negedge I_clk);
      if (rnd_rdy)
        bus.I_wr_data_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge I_clk);
    bus.I_frame_start = 1'b1;
    @(negedge I_clk);
    bus.I_frame_start = 1'b0;
  endtask

  task automatic send_px(input int n, input int base);
    int i;
    int g;
    i = 0;
    g = 0;
    while (i < n && g < 4000) begin
      @(negedge I_clk);
      bus.I_pix_valid = 1'b1;
      bus.I_pix_data  = 16'(base + i);
      #1;
      if (bus.O_pix_ready) i++;
      g++;
    end
    @(negedge I_clk);
    bus.I_pix_valid = 1'b0;
    chk("px_sent", 128'(i), 128'(n));
  endtask

  task automatic wait_done();
    int g;
    g = 0;
    while (n_done < exp_done && g < 3000) begin
      @(negedge I_clk);
      g++;
    end
    @(negedge I_clk);
    #3;
    chk("frame_done", 128'(n_done), 128'(exp_done));
    chk("frame_idx", 128'(bus.O_frame_idx), 128'(m_idx));
  endtask

  task automatic chk_outs_zero(input string pfx);
    chk({pfx, "_ready"}, 128'(bus.O_pix_ready), 0);
    chk({pfx, "_cmd_en"}, 128'(bus.O_cmd_en), 0);
    chk({pfx, "_addr"}, 128'(bus.O_addr), 0);
    chk({pfx, "_wr_en"}, 128'(bus.O_wr_data_en), 0);
    chk({pfx, "_wr_end"}, 128'(bus.O_wr_data_end), 0);
    chk({pfx, "_wr_data"}, bus.O_wr_data, 0);
    chk({pfx, "_done"}, 128'(bus.O_frame_done), 0);
    chk({pfx, "_err"}, 128'(bus.O_frame_err), 0);
    chk({pfx, "_idx"}, 128'(bus.O_frame_idx), 0);
    chk({pfx, "_cmd"}, 128'(bus.O_cmd), 0);
    chk({pfx, "_mask"}, 128'(bus.O_wr_data_mask), 0);
    chk({pfx, "_bn"}, 128'(bus.O_burst_number), 128'(BB - 1));
  endtask

  initial begin
    int acc;
    int g;
    bus.I_calib_done  = 1'b1;
    bus.I_frame_start = 1'b0;
    bus.I_pix_data    = '0;
    bus.I_pix_valid   = 1'b0;
    bus.I_cmd_ready   = 1'b1;
    bus.I_wr_data_rdy = 1'b1;
    I_rst = 1'b1;
    repeat (3) @(negedge I_clk);
    #1;
    chk_outs_zero("rst");
    @(negedge I_clk);
    I_rst = 1'b0;

    // Frame 0: pixels 0..127, no backpressure
    pulse_start();
    send_px(FP, 0);
    wait_done();
    chk("f0_cmds", 128'(n_cmd), 128'(8));
    chk("f0_first_word", first_beat,
        128'h0007_0006_0005_0004_0003_0002_0001_0000);
    chk("f0_idx_one", 128'(bus.O_frame_idx), 128'(1));

    // Three more frames: bases 4096, 8192, then 0
    for (int f = 1; f < 4; f++) begin
      pulse_start();
      send_px(FP, f * FP);
      wait_done();
    end

    // Command backpressure: both banks fill, ready drops
    bus.I_cmd_ready = 1'b0;
    pulse_start();
    acc = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge I_clk);
      bus.I_pix_valid = 1'b1;
      bus.I_pix_data  = 16'(1000 + acc);
      #1;
      if (bus.O_pix_ready) acc++;
    end
    chk("hold_acc", 128'(acc), 128'(2 * BB * 8));
    chk("hold_ready", 128'(bus.O_pix_ready), 0);
    chk("hold_cmd_en", 128'(bus.O_cmd_en), 1);
    bus.I_cmd_ready = 1'b1;
    send_px(FP - acc, 1000 + acc);
    wait_done();

    // Random write-data gaps
    rnd_rdy = 1'b1;
    pulse_start();
    send_px(FP, 3000);
    wait_done();
    rnd_rdy = 1'b0;
    @(negedge I_clk);
    bus.I_wr_data_rdy = 1'b1;

    // Early frame start after 40 pixels
    pulse_start();
    send_px(40, 5000);
    repeat (10) @(negedge I_clk);
    chk("abort_q", 128'(q_addr.size()), 0);
    @(negedge I_clk);
    bus.I_frame_start = 1'b1;
    model_abort();
    @(negedge I_clk);
    bus.I_frame_start = 1'b0;
    repeat (3) @(negedge I_clk);
    #3;
    chk("abort_err", 128'(n_errp), 128'(1));
    chk("abort_no_done", 128'(n_done), 128'(exp_done));
    chk("abort_idx", 128'(bus.O_frame_idx), 128'(m_idx));
    send_px(FP, 6000);
    wait_done();

    // Reset while a burst sits in the data phase
    bus.I_wr_data_rdy = 1'b0;
    pulse_start();
    send_px(BB * 8, 7000);
    g = 0;
    #1;
    while (!bus.O_wr_data_en && g < 50) begin
      @(negedge I_clk);
      #1;
      g++;
    end
    chk("wdata_reached", 128'(bus.O_wr_data_en), 1);
    @(negedge I_clk);
    I_rst = 1'b1;
    @(negedge I_clk);
    #1;
    chk_outs_zero("mid_rst");
    model_reset();
    bus.I_wr_data_rdy = 1'b1;
    @(negedge I_clk);
    I_rst = 1'b0;
    pulse_start();
    send_px(FP, 9000);
    wait_done();

    repeat (5) @(negedge I_clk);
    #3;
    chk("end_q_addr", 128'(q_addr.size()), 0);
    chk("end_q_beat", 128'(q_beat.size()), 0);
    chk("end_err_cnt", 128'(n_errp), 128'(1));
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
